interrupt_controller: RTL and testbench

Upstream neighbour of the game processor: collects keyboard scancodes and an optional periodic timer tick, and presents them to the processor as a 2-bit interrupt request. Buffers keys in a small FIFO so strokes arriving while the processor is busy are not lost. Runs the IACK/IEND handshake and holds the serviced scancode on `KBD_KEY` for the whole service window.

---
 rtl/intc_pkg.sv | 25 ++
 rtl/intc_key_fifo.sv | 68 ++++++
 rtl/interrupt_controller.sv | 132 +++++++++++++
 tb/tb_interrupt_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared constants, state encoding and the request arbitration rule for
// interrupt_controller and its key FIFO.
package intc_pkg;

    localparam logic [1:0] IRQ_NONE  = 2'd0;
    localparam logic [1:0] IRQ_KBD   = 2'd1;
    localparam logic [1:0] IRQ_TIMER = 2'd2;

    typedef enum logic {
        ST_WAIT    = 1'b0,
        ST_SERVICE = 1'b1
    } intc_state_e;

    // Queued keys always beat a pending timer tick.
    function automatic logic [1:0] arbitrate(input logic fifo_empty, input logic timer_pend);
        if (!fifo_empty) begin
            return IRQ_KBD;
        end else if (timer_pend) begin
            return IRQ_TIMER;
        end else begin
            return IRQ_NONE;
        end
    endfunction

endpackage

// File: rtl/intc_key_fifo.sv
// Scancode FIFO: power-of-two depth, naturally wrapping pointers, count one bit
// wider than the pointers. A push while full is accepted only alongside a pop.
module intc_key_fifo
    import intc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_accept;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign head        = mem_q[rd_ptr_q];
    assign push_accept = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_accept, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Keyboard/timer interrupt source with IACK/IEND handshake for the game processor.
// Optional periodic timer request is built only when INTC_TIMER_EN is defined.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          KEY_DEPTH    = 4,
    parameter logic [15:0] TIMER_PERIOD = 16'd50000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       KEY_VALID,
    input  logic [7:0] KEY_CODE,
    output logic [1:0] INT_IRQ,
    input  logic       INT_IACK,
    input  logic       INT_IEND,
    output logic [7:0] KBD_KEY,
    output logic       KEY_OVERFLOW
);

    intc_state_e state_q, state_d;
    logic [1:0]  irq_q, irq_d;
    logic [7:0]  kbd_q, kbd_d;
    logic        ovf_q, ovf_d;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        timer_pend;
    logic        timer_grant;

    intc_key_fifo #(
        .DEPTH (KEY_DEPTH)
    ) u_key_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (KEY_VALID),
        .pop   (fifo_pop),
        .din   (KEY_CODE),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

`ifdef INTC_TIMER_EN
    logic [15:0] timer_cnt_q, timer_cnt_d;
    logic        timer_pend_q, timer_pend_d;
    logic        timer_tick;

    assign timer_tick = (timer_cnt_q == TIMER_PERIOD - 16'd1);
    assign timer_pend = timer_pend_q;

    // A tick on the same edge as a timer grant wins, so that request is not lost.
    always_comb begin
        timer_cnt_d  = timer_tick ? 16'd0 : timer_cnt_q + 16'd1;
        timer_pend_d = timer_pend_q;
        if (timer_tick) begin
            timer_pend_d = 1'b1;
        end else if (timer_grant) begin
            timer_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            timer_cnt_q  <= 16'd0;
            timer_pend_q <= 1'b0;
        end else begin
            timer_cnt_q  <= timer_cnt_d;
            timer_pend_q <= timer_pend_d;
        end
    end
`else
    logic unused_timer;
    assign timer_pend   = 1'b0;
    assign unused_timer = ^{TIMER_PERIOD, timer_grant};
`endif

    always_comb begin
        state_d     = state_q;
        irq_d       = irq_q;
        kbd_d       = kbd_q;
        fifo_pop    = 1'b0;
        timer_grant = 1'b0;
        case (state_q)
            ST_WAIT: begin
                // The grant applies to the request the processor saw, not a fresh arbitration.
                if (INT_IACK && (irq_q != IRQ_NONE)) begin
                    irq_d   = IRQ_NONE;
                    state_d = ST_SERVICE;
                    if (irq_q == IRQ_KBD) begin
                        kbd_d    = fifo_head;
                        fifo_pop = 1'b1;
                    end else begin
                        timer_grant = 1'b1;
                    end
                end else begin
                    irq_d = arbitrate(fifo_empty, timer_pend);
                end
            end
            ST_SERVICE: begin
                irq_d = IRQ_NONE;
                if (INT_IEND) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
                irq_d   = IRQ_NONE;
            end
        endcase
        ovf_d = ovf_q | (KEY_VALID & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_WAIT;
            irq_q   <= IRQ_NONE;
            kbd_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            kbd_q   <= kbd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign INT_IRQ      = irq_q;
    assign KBD_KEY      = kbd_q;
    assign KEY_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_interrupt_controller;

    localparam int          TB_DEPTH  = 4;
    localparam logic [15:0] TB_PERIOD = 16'd8;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       KEY_VALID = 1'b0;
    logic [7:0] KEY_CODE = 8'h00;
    logic       INT_IACK = 1'b0;
    logic       INT_IEND = 1'b0;
    logic [1:0] INT_IRQ;
    logic [7:0] KBD_KEY;
    logic       KEY_OVERFLOW;

    interrupt_controller #(
        .KEY_DEPTH    (TB_DEPTH),
        .TIMER_PERIOD (TB_PERIOD)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .KEY_VALID    (KEY_VALID),
        .KEY_CODE     (KEY_CODE),
        .INT_IRQ      (INT_IRQ),
        .INT_IACK     (INT_IACK),
        .INT_IEND     (INT_IEND),
        .KBD_KEY      (KBD_KEY),
        .KEY_OVERFLOW (KEY_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the processor should observe, from the behavioural rules.
    logic [7:0] mq[$];
    int         m_irq  = 0;
    logic [7:0] m_kbd  = 8'h00;
    bit         m_ovf  = 0;
    bit         m_serv = 0;
    bit         m_pend = 0;
    int         m_cnt  = 0;

    typedef struct {
        logic       v;
        logic [7:0] code;
        logic       ia;
        logic       ie;
        logic [1:0] irq;
        logic [7:0] kbd;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rn, input logic v, input logic [7:0] c,
                              input logic ia, input logic ie);
        int arb;
        int nirq;
        bit pop;
        bit tgrant;
        bit tick;
        pop    = 0;
        tgrant = 0;
        if (!rn) begin
            mq.delete();
            m_irq  = 0;
            m_kbd  = 8'h00;
            m_ovf  = 0;
            m_serv = 0;
            m_pend = 0;
            m_cnt  = 0;
        end else begin
            arb = (mq.size() != 0) ? 1 : (m_pend ? 2 : 0);
            if (!m_serv) begin
                if (ia && m_irq != 0) begin
                    nirq   = 0;
                    m_serv = 1;
                    if (m_irq == 1) pop = 1;
                    else tgrant = 1;
                end else begin
                    nirq = arb;
                end
            end else begin
                nirq = 0;
                if (ie) m_serv = 0;
            end
            if (pop) m_kbd = mq.pop_front();
            if (v) begin
                if (mq.size() < TB_DEPTH) mq.push_back(c);
                else m_ovf = 1;
            end
`ifdef INTC_TIMER_EN
            tick  = (m_cnt == int'(TB_PERIOD) - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            if (tick) m_pend = 1;
            else if (tgrant) m_pend = 0;
`else
            tick = 0;
`endif
            m_irq = nirq;
        end
    endtask

    task automatic step(input logic rn, input logic v, input logic [7:0] c,
                        input logic ia, input logic ie);
        @(negedge CLK);
        RESET_N   = rn;
        KEY_VALID = v;
        KEY_CODE  = c;
        INT_IACK  = ia;
        INT_IEND  = ie;
        @(posedge CLK);
        model_edge(rn, v, c, ia, ie);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".irq"}, 32'(INT_IRQ), 32'(m_irq));
        chk({tag, ".kbd"}, 32'(KBD_KEY), 32'(m_kbd));
        chk({tag, ".ovf"}, 32'(KEY_OVERFLOW), 32'(m_ovf));
    endtask

    task automatic add(input logic v, input logic [7:0] c, input logic ia, input logic ie,
                       input logic [1:0] irq, input logic [7:0] kbd, input logic ovf);
        vec_t r;
        r.v = v; r.code = c; r.ia = ia; r.ie = ie;
        r.irq = irq; r.kbd = kbd; r.ovf = ovf;
        tbl.push_back(r);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset.irq", 32'(INT_IRQ), 32'd0);
        chk("reset.kbd", 32'(KBD_KEY), 32'd0);
        chk("reset.ovf", 32'(KEY_OVERFLOW), 32'd0);

`ifndef INTC_TIMER_EN
        // Single key, ignored pulses, then a 5-key burst into a 4-deep FIFO.
        add(1, 8'h1C, 0, 0, 2'd0, 8'h00, 0);
        add(0, 8'h00, 0, 0, 2'd1, 8'h00, 0);
        add(0, 8'h00, 1, 0, 2'd0, 8'h1C, 0);
        add(0, 8'h00, 0, 0, 2'd0, 8'h1C, 0);
        add(0, 8'h00, 1, 0, 2'd0, 8'h1C, 0);
        add(0, 8'h00, 0, 1, 2'd0, 8'h1C, 0);
        add(0, 8'h00, 0, 0, 2'd0, 8'h1C, 0);
        add(0, 8'h00, 0, 1, 2'd0, 8'h1C, 0);
        add(0, 8'h00, 1, 0, 2'd0, 8'h1C, 0);
        add(1, 8'h01, 0, 0, 2'd0, 8'h1C, 0);
        add(1, 8'h02, 0, 0, 2'd1, 8'h1C, 0);
        add(1, 8'h03, 0, 0, 2'd1, 8'h1C, 0);
        add(1, 8'h04, 0, 0, 2'd1, 8'h1C, 0);
        add(1, 8'h05, 0, 0, 2'd1, 8'h1C, 1);
        add(0, 8'h00, 1, 0, 2'd0, 8'h01, 1);
        add(0, 8'h00, 0, 1, 2'd0, 8'h01, 1);
        add(0, 8'h00, 0, 0, 2'd1, 8'h01, 1);
        add(0, 8'h00, 1, 0, 2'd0, 8'h02, 1);
        add(0, 8'h00, 0, 1, 2'd0, 8'h02, 1);
        add(0, 8'h00, 0, 0, 2'd1, 8'h02, 1);
        add(0, 8'h00, 1, 0, 2'd0, 8'h03, 1);
        add(0, 8'h00, 0, 1, 2'd0, 8'h03, 1);
        add(0, 8'h00, 0, 0, 2'd1, 8'h03, 1);
        add(0, 8'h00, 1, 0, 2'd0, 8'h04, 1);
        add(0, 8'h00, 0, 1, 2'd0, 8'h04, 1);
        add(0, 8'h00, 0, 0, 2'd0, 8'h04, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].v, tbl[i].code, tbl[i].ia, tbl[i].ie);
            $display("vec %0d: v=%0b code=%02h iack=%0b iend=%0b -> irq=%0d kbd=%02h ovf=%0b",
                     i, tbl[i].v, tbl[i].code, tbl[i].ia, tbl[i].ie, INT_IRQ, KBD_KEY, KEY_OVERFLOW);
            chk($sformatf("vec%0d.irq", i), 32'(INT_IRQ), 32'(tbl[i].irq));
            chk($sformatf("vec%0d.kbd", i), 32'(KBD_KEY), 32'(tbl[i].kbd));
            chk($sformatf("vec%0d.ovf", i), 32'(KEY_OVERFLOW), 32'(tbl[i].ovf));
        end

        // Key arriving during service waits until after IEND.
        step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        idle();
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("svc.kbd10", 32'(KBD_KEY), 32'h10);
        step(1'b1, 1'b1, 8'h2A, 1'b0, 1'b0);
        chk("svc.irq_hold0", 32'(INT_IRQ), 32'd0);
        idle();
        chk("svc.irq_hold1", 32'(INT_IRQ), 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("svc.irq_iend", 32'(INT_IRQ), 32'd0);
        idle();
        chk("svc.irq_after", 32'(INT_IRQ), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("svc.kbd2A", 32'(KBD_KEY), 32'h2A);
        $display("service-window key delivered kbd=%02h", KBD_KEY);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
`else
        // Timer pending then preempted by a key; key served first, then timer.
        for (int i = 1; i <= 9; i++) begin
            idle();
            if (i == 8) chk("tmr.irq_before", 32'(INT_IRQ), 32'd0);
        end
        chk("tmr.irq_pend", 32'(INT_IRQ), 32'd2);
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        idle();
        chk("tmr.preempt", 32'(INT_IRQ), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("tmr.kbd33", 32'(KBD_KEY), 32'h33);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        chk("tmr.irq_timer", 32'(INT_IRQ), 32'd2);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("tmr.grant_irq", 32'(INT_IRQ), 32'd0);
        chk("tmr.kbd_keep", 32'(KBD_KEY), 32'h33);
        $display("timer served after key, kbd=%02h", KBD_KEY);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check_model("tmr.end");
`endif

        // Reset for one edge while in service with 3 keys queued.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        idle();
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst.irq", 32'(INT_IRQ), 32'd0);
        chk("rst.kbd", 32'(KBD_KEY), 32'd0);
        chk("rst.ovf", 32'(KEY_OVERFLOW), 32'd0);
        idle();
        idle();
        chk("rst.empty", 32'(INT_IRQ), 32'd0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        idle();
        chk("rst.newirq", 32'(INT_IRQ), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst.newkey", 32'(KBD_KEY), 32'h55);
        $display("post-reset key delivered kbd=%02h", KBD_KEY);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Ten keys one at a time, crossing the pointer wrap twice.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            idle();
`ifndef INTC_TIMER_EN
            chk($sformatf("wrap%0d.irq", i), 32'(INT_IRQ), 32'd1);
`endif
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("wrap%0d.kbd", i), 32'(KBD_KEY), 32'(8'hA0 + 8'(i)));
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            $display("wrap key %0d delivered kbd=%02h", i, KBD_KEY);
        end
        chk("wrap.ovf", 32'(KEY_OVERFLOW), 32'd0);

        // Randomized traffic against the reference model.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_model("rnd.reset");
        for (int n = 0; n < 3000; n++) begin
            logic rn;
            logic v;
            logic ia;
            logic ie;
            logic [7:0] c;
            rn = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 99) < 35);
            ia = ($urandom_range(0, 99) < 30);
            ie = ($urandom_range(0, 99) < 25);
            c  = 8'($urandom);
            step(rn, v, c, ia, ie);
            check_model($sformatf("rnd%0d", n));
            if (rn && ia && INT_IRQ == 2'd0 && m_serv && n % 50 == 0)
                $display("rnd %0d: granted, kbd=%02h ovf=%0b", n, KBD_KEY, KEY_OVERFLOW);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
